// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry, write-back bundle and operand fetch states.
package regfile_pkg;

  localparam int unsigned M  = 32;
  localparam int unsigned N  = 32;
  localparam int unsigned AW = $clog2(M);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] rw;
    logic [N-1:0]  data;
  } wb_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StHold
  } ofs_state_e;

endpackage

// File: rtl/operand_bypass.sv
// Selects the write-port data over a base operand when the write targets the operand's
// register; address 0 can be hard-wired to zero.
module operand_bypass #(
  parameter int unsigned AW      = 5,
  parameter int unsigned N       = 32,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic [AW-1:0] rs,
  input  logic [N-1:0]  base,
  input  logic          we,
  input  logic [AW-1:0] rw,
  input  logic [N-1:0]  data,
  output logic [N-1:0]  q
);

  always_comb begin
    q = base;
    if (we && (rw == rs)) begin
      q = data;
    end
    // Zero register wins over both the file contents and any write aimed at it.
    if (R0_ZERO && (rs == '0)) begin
      q = '0;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: issues register-file reads, repairs read-before-write staleness by snooping
// the shared write port, and hands operands to execute over a valid/ready handshake.
module operand_fetch_stage #(
  parameter int unsigned M       = 32,
  parameter int unsigned N       = 32,
  parameter int unsigned TAG_W   = 8,
  parameter bit          R0_ZERO = 1'b0,
  localparam int unsigned AW     = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [AW-1:0]    rf_r1,
  output logic [AW-1:0]    rf_r2,
  input  logic [N-1:0]     rf_q1,
  input  logic [N-1:0]     rf_q2,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_rw,
  input  logic [N-1:0]     wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_op1,
  output logic [N-1:0]     out_op2,
  output logic [TAG_W-1:0] out_tag
);

  import regfile_pkg::*;

  ofs_state_e state_q, state_d;

  logic [AW-1:0]    rs1_q, rs2_q;
  logic [TAG_W-1:0] tag_q;
  logic [N-1:0]     hold_op1_q, hold_op1_d;
  logic [N-1:0]     hold_op2_q, hold_op2_d;
  logic             lw_we_q;
  logic [AW-1:0]    lw_rw_q;
  logic [N-1:0]     lw_data_q;

  logic         issue;
  logic         stall;
  logic [N-1:0] read_op1, read_op2;
  logic [N-1:0] snoop_op1, snoop_op2;

  // The file samples the request addresses directly; data returns next cycle.
  assign rf_r1 = in_rs1;
  assign rf_r2 = in_rs2;

  assign in_ready  = (state_q == StIdle) || out_ready;
  assign out_valid = (state_q != StIdle);
  assign out_tag   = tag_q;
  assign issue     = in_valid && in_ready;
  assign stall     = out_valid && !out_ready;

  // READ path: the file misses the write at the issue edge, which lw_* still carries.
  operand_bypass #(
    .AW      (AW),
    .N       (N),
    .R0_ZERO (R0_ZERO)
  ) u_read_op1 (
    .rs   (rs1_q),
    .base (rf_q1),
    .we   (lw_we_q),
    .rw   (lw_rw_q),
    .data (lw_data_q),
    .q    (read_op1)
  );

  operand_bypass #(
    .AW      (AW),
    .N       (N),
    .R0_ZERO (R0_ZERO)
  ) u_read_op2 (
    .rs   (rs2_q),
    .base (rf_q2),
    .we   (lw_we_q),
    .rw   (lw_rw_q),
    .data (lw_data_q),
    .q    (read_op2)
  );

  // Snoop path: while stalled, writes landing at an edge refresh the held operands.
  operand_bypass #(
    .AW      (AW),
    .N       (N),
    .R0_ZERO (R0_ZERO)
  ) u_snoop_op1 (
    .rs   (rs1_q),
    .base (out_op1),
    .we   (wb_we),
    .rw   (wb_rw),
    .data (wb_data),
    .q    (snoop_op1)
  );

  operand_bypass #(
    .AW      (AW),
    .N       (N),
    .R0_ZERO (R0_ZERO)
  ) u_snoop_op2 (
    .rs   (rs2_q),
    .base (out_op2),
    .we   (wb_we),
    .rw   (wb_rw),
    .data (wb_data),
    .q    (snoop_op2)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = StRead;
        end
      end
      StRead, StHold: begin
        if (out_ready) begin
          state_d = issue ? StRead : StIdle;
        end else begin
          state_d = StHold;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_op1    = read_op1;
    out_op2    = read_op2;
    hold_op1_d = hold_op1_q;
    hold_op2_d = hold_op2_q;
    if (state_q == StHold) begin
      out_op1 = hold_op1_q;
      out_op2 = hold_op2_q;
    end
    if (stall) begin
      hold_op1_d = snoop_op1;
      hold_op2_d = snoop_op2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rs1_q      <= '0;
      rs2_q      <= '0;
      tag_q      <= '0;
      hold_op1_q <= '0;
      hold_op2_q <= '0;
      lw_we_q    <= 1'b0;
      lw_rw_q    <= '0;
      lw_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_op1_q <= hold_op1_d;
      hold_op2_q <= hold_op2_d;
      lw_we_q    <= wb_we;
      lw_rw_q    <= wb_rw;
      lw_data_q  <= wb_data;
      if (issue) begin
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        tag_q <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench: a registered 32x32 file model feeds two stage instances, one with the
// zero register enabled; inputs change and outputs are sampled around the falling edge.
module tb_operand_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  in_rs1, in_rs2;
  logic [7:0]  in_tag;
  logic [31:0] rf_q1, rf_q2;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [31:0] wb_data;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [4:0]  rf_r1, rf_r2;
  logic [31:0] out_op1, out_op2;
  logic [7:0]  out_tag;

  logic        z_in_ready, z_out_valid;
  logic [4:0]  z_rf_r1, z_rf_r2;
  logic [31:0] z_out_op1, z_out_op2;
  logic [7:0]  z_out_tag;

  logic [31:0] mem [32];

  int vectors    = 0;
  int miscompares = 0;

  operand_fetch_stage #(
    .M       (32),
    .N       (32),
    .TAG_W   (8),
    .R0_ZERO (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_tag    (in_tag),
    .rf_r1     (rf_r1),
    .rf_r2     (rf_r2),
    .rf_q1     (rf_q1),
    .rf_q2     (rf_q2),
    .wb_we     (wb_we),
    .wb_rw     (wb_rw),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op1   (out_op1),
    .out_op2   (out_op2),
    .out_tag   (out_tag)
  );

  operand_fetch_stage #(
    .M       (32),
    .N       (32),
    .TAG_W   (8),
    .R0_ZERO (1'b1)
  ) dut_z (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (z_in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_tag    (in_tag),
    .rf_r1     (z_rf_r1),
    .rf_r2     (z_rf_r2),
    .rf_q1     (rf_q1),
    .rf_q2     (rf_q2),
    .wb_we     (wb_we),
    .wb_rw     (wb_rw),
    .wb_data   (wb_data),
    .out_valid (z_out_valid),
    .out_ready (out_ready),
    .out_op1   (z_out_op1),
    .out_op2   (z_out_op2),
    .out_tag   (z_out_tag)
  );

  always #5 clk = ~clk;

  // Registered-read file with read-before-write, as the stage expects.
  always @(posedge clk) begin
    if (wb_we) mem[wb_rw] <= wb_data;
    rf_q1 <= mem[rf_r1];
    rf_q2 <= mem[rf_r2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_we   = 1'b1;
    wb_rw   = a;
    wb_data = d;
    @(negedge clk);
    wb_we   = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    wb_we = 1'b0; wb_rw = '0; wb_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    rst_n = 1'b1;

    wr(5'd5, 32'hAAAA_0001);
    wr(5'd6, 32'h6666_0006);
    wr(5'd7, 32'h7777_0007);
    wr(5'd9, 32'h9999_0009);
    for (int i = 1; i <= 4; i++) wr(5'(i), 32'h11 * 32'(i));

    // 1: plain read, tag carried
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_tag = 8'h3C; out_ready = 1'b1;
    #1 chk("t1_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_op1", out_op1, 32'hAAAA_0001);
    chk("t1_op2", out_op2, 32'h6666_0006);
    chk("t1_tag", 32'(out_tag), 32'h3C);
    @(negedge clk);
    #1 chk("t1_idle", 32'(out_valid), 32'd0);

    // 2: write at the issue edge must be bypassed
    in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd5; in_tag = 8'h11;
    wb_we = 1'b1; wb_rw = 5'd7; wb_data = 32'h1234_5678;
    @(negedge clk);
    in_valid = 1'b0; wb_we = 1'b0;
    #1;
    chk("t2_op1", out_op1, 32'h1234_5678);
    chk("t2_op2", out_op2, 32'hAAAA_0001);
    @(negedge clk);

    // 3: stall with a write mid-stall; write in the accept cycle excluded
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd9; in_tag = 8'h22; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t3_s1_valid", 32'(out_valid), 32'd1);
    chk("t3_s1_in_ready", 32'(in_ready), 32'd0);
    chk("t3_s1_op2", out_op2, 32'h9999_0009);
    @(negedge clk);
    wb_we = 1'b1; wb_rw = 5'd9; wb_data = 32'hDEAD_BEEF;
    #1 chk("t3_s2_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    wb_we = 1'b0;
    #1;
    chk("t3_s3_valid", 32'(out_valid), 32'd1);
    chk("t3_s3_op2", out_op2, 32'hDEAD_BEEF);
    @(negedge clk);
    out_ready = 1'b1; wb_we = 1'b1; wb_rw = 5'd9; wb_data = 32'h0BAD_0BAD;
    #1;
    chk("t3_acc_valid", 32'(out_valid), 32'd1);
    chk("t3_acc_op1", out_op1, 32'hAAAA_0001);
    chk("t3_acc_op2", out_op2, 32'hDEAD_BEEF);
    chk("t3_acc_tag", 32'(out_tag), 32'h22);
    @(negedge clk);
    wb_we = 1'b0;
    #1 chk("t3_done", 32'(out_valid), 32'd0);

    // 4: back-to-back issues
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rs1 = 5'(i); in_rs2 = 5'd6; in_tag = 8'(i); out_ready = 1'b1;
      #1;
      chk("t4_in_ready", 32'(in_ready), 32'd1);
      chk("t4_valid", 32'(out_valid), (i > 1) ? 32'd1 : 32'd0);
      if (i > 1) begin
        chk("t4_op1", out_op1, 32'h11 * 32'(i - 1));
        chk("t4_op2", out_op2, 32'h6666_0006);
        chk("t4_tag", 32'(out_tag), 32'(i - 1));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("t4_last_valid", 32'(out_valid), 32'd1);
    chk("t4_last_op1", out_op1, 32'h44);
    chk("t4_last_tag", 32'(out_tag), 32'd4);
    @(negedge clk);
    #1 chk("t4_done", 32'(out_valid), 32'd0);

    // 5: zero register, in READ and in HOLD with a snooped write to r0
    wr(5'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_tag = 8'h05; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; wb_we = 1'b1; wb_rw = 5'd0; wb_data = 32'h0000_1234;
    #1;
    chk("t5_z_rd_op1", z_out_op1, 32'd0);
    chk("t5_z_rd_op2", z_out_op2, 32'd0);
    chk("t5_nz_rd_op1", out_op1, 32'hFFFF_FFFF);
    chk("t5_nz_rd_op2", out_op2, 32'hFFFF_FFFF);
    @(negedge clk);
    wb_we = 1'b0;
    #1;
    chk("t5_z_valid", 32'(z_out_valid), 32'd1);
    chk("t5_z_hold_op1", z_out_op1, 32'd0);
    chk("t5_z_hold_op2", z_out_op2, 32'd0);
    chk("t5_nz_hold_op1", out_op1, 32'h0000_1234);
    chk("t5_z_tag", 32'(z_out_tag), 32'h05);
    chk("t5_z_rf_r1", 32'(z_rf_r1), 32'd0);
    chk("t5_z_rf_r2", 32'(z_rf_r2), 32'd0);
    chk("t5_z_in_ready", 32'(z_in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    #1 chk("t5_done", 32'(z_out_valid), 32'd0);

    // 6: asynchronous reset while holding
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_tag = 8'h77; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_hold_valid", 32'(out_valid), 32'd1);
    chk("t6_hold_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_rel_valid", 32'(out_valid), 32'd0);
    chk("t6_rel_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1 chk("t6_no_spurious", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
